xvga_timing: RTL and testbench

- Generates raster timing for the 1024x768 display path: hcount, vcount, hsync, vsync and blank.
- Sits directly upstream of the graphics stage and feeds its hcount/vcount/hsync/vsync/blank inputs.
- Also produces frame- and line-rate strobes, a wrapping frame counter (for sprite animation and blinking) and a once-per-second game tick (drives the time_left countdown).

---
 rtl/xvga_timing.sv | 141 ++++++++++++++
 tb/tb_xvga_timing.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/xvga_timing.sv
// Raster timing generator for the 1024x768 path: counters, syncs and blank,
// plus line/frame strobes, a wrapping frame counter and a once-per-N-frames game tick.
module xvga_timing #(
  parameter int H_ACTIVE        = 1024,
  parameter int H_FP            = 24,
  parameter int H_SYNC          = 136,
  parameter int H_BP            = 160,
  parameter int V_ACTIVE        = 768,
  parameter int V_FP            = 3,
  parameter int V_SYNC          = 6,
  parameter int V_BP            = 29,
  parameter int FRAMES_PER_TICK = 60
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        pixel_en,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        line_start,
  output logic        frame_start,
  output logic [7:0]  frame_count,
  output logic        game_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int TICK_W  = (FRAMES_PER_TICK > 1) ? $clog2(FRAMES_PER_TICK) : 1;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_VIS_END  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_VIS_END  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(FRAMES_PER_TICK - 1);

  logic [10:0]       hcount_q, hcount_d;
  logic [9:0]        vcount_q, vcount_d;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic              blank_q, blank_d;
  logic              line_start_q, line_start_d;
  logic              frame_start_q, frame_start_d;
  logic [7:0]        frame_count_q, frame_count_d;
  logic              game_tick_q, game_tick_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;

  logic              h_wrap;
  logic              v_wrap;
  logic [10:0]       h_next;
  logic [9:0]        v_next;

  // Flags are derived from the next counts so they leave the flops aligned with them.
  always_comb begin
    h_wrap = (hcount_q == H_LAST);
    v_wrap = h_wrap && (vcount_q == V_LAST);
    h_next = h_wrap ? 11'd0 : hcount_q + 11'd1;
    if (h_wrap) begin
      v_next = v_wrap ? 10'd0 : vcount_q + 10'd1;
    end else begin
      v_next = vcount_q;
    end

    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    blank_d       = blank_q;
    frame_count_d = frame_count_q;
    tick_cnt_d    = tick_cnt_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    game_tick_d   = 1'b0;

    if (pixel_en) begin
      hcount_d      = h_next;
      vcount_d      = v_next;
      blank_d       = (h_next >= H_VIS_END) || (v_next >= V_VIS_END);
      hsync_d       = !((h_next >= HS_START) && (h_next < HS_END));
      vsync_d       = !((v_next >= VS_START) && (v_next < VS_END));
      line_start_d  = h_wrap;
      frame_start_d = v_wrap;
      if (v_wrap) begin
        frame_count_d = frame_count_q + 8'd1;
        if (tick_cnt_q == TICK_LAST) begin
          tick_cnt_d  = '0;
          game_tick_d = 1'b1;
        end else begin
          tick_cnt_d  = tick_cnt_q + TICK_W'(1);
          game_tick_d = 1'b0;
        end
      end else begin
        frame_count_d = frame_count_q;
      end
    end else begin
      hcount_d = hcount_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hcount_q      <= 11'd0;
      vcount_q      <= 10'd0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      blank_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= 8'd0;
      game_tick_q   <= 1'b0;
      tick_cnt_q    <= '0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_q       <= blank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
      game_tick_q   <= game_tick_d;
      tick_cnt_q    <= tick_cnt_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank       = blank_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;
  assign game_tick   = game_tick_q;

endmodule

// File: tb/tb_xvga_timing.sv
// Bench for xvga_timing: three configurations (default, tiny, default-H/short-V)
// checked every cycle against a linear-pixel-position model plus literal expectations.
module tb_xvga_timing;

  localparam int HT_A = 1344, TOT_A = 1344 * 806;
  localparam int HT_B = 7,    TOT_B = 7 * 5;
  localparam int HT_C = 1344, TOT_C = 1344 * 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic pen;

  logic [10:0] a_h, b_h, c_h;
  logic [9:0]  a_v, b_v, c_v;
  logic a_hs, a_vs, a_bl, a_ls, a_fs, a_gt;
  logic b_hs, b_vs, b_bl, b_ls, b_fs, b_gt;
  logic c_hs, c_vs, c_bl, c_ls, c_fs, c_gt;
  logic [7:0] a_fc, b_fc, c_fc;

  xvga_timing dut_a (
    .clock(clk), .reset_n(rst_n), .pixel_en(pen),
    .hcount(a_h), .vcount(a_v), .hsync(a_hs), .vsync(a_vs), .blank(a_bl),
    .line_start(a_ls), .frame_start(a_fs), .frame_count(a_fc), .game_tick(a_gt)
  );

  xvga_timing #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .FRAMES_PER_TICK(3)
  ) dut_b (
    .clock(clk), .reset_n(rst_n), .pixel_en(pen),
    .hcount(b_h), .vcount(b_v), .hsync(b_hs), .vsync(b_vs), .blank(b_bl),
    .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc), .game_tick(b_gt)
  );

  xvga_timing #(
    .V_ACTIVE(4), .V_FP(3), .V_SYNC(6), .V_BP(2)
  ) dut_c (
    .clock(clk), .reset_n(rst_n), .pixel_en(pen),
    .hcount(c_h), .vcount(c_v), .hsync(c_hs), .vsync(c_vs), .blank(c_bl),
    .line_start(c_ls), .frame_start(c_fs), .frame_count(c_fc), .game_tick(c_gt)
  );

  int nchk = 0;
  int nfail = 0;

  task automatic chk(input string nm, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      nfail++;
      if (nfail <= 30) $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Model: position p is the linear pixel index within the frame, fr counts frame starts.
  int  ma_p, ma_fr, mb_p, mb_fr, mc_p, mc_fr;
  logic ma_ls, ma_fs, ma_gt, mb_ls, mb_fs, mb_gt, mc_ls, mc_fs, mc_gt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma_p <= 0; ma_fr <= 0; ma_ls <= 1'b0; ma_fs <= 1'b0; ma_gt <= 1'b0;
      mb_p <= 0; mb_fr <= 0; mb_ls <= 1'b0; mb_fs <= 1'b0; mb_gt <= 1'b0;
      mc_p <= 0; mc_fr <= 0; mc_ls <= 1'b0; mc_fs <= 1'b0; mc_gt <= 1'b0;
    end else if (pen) begin
      ma_p  <= (ma_p + 1) % TOT_A;
      ma_ls <= ((ma_p + 1) % HT_A) == 0;
      ma_fs <= (ma_p + 1) == TOT_A;
      ma_fr <= ma_fr + (((ma_p + 1) == TOT_A) ? 1 : 0);
      ma_gt <= ((ma_p + 1) == TOT_A) && (((ma_fr + 1) % 60) == 0);
      mb_p  <= (mb_p + 1) % TOT_B;
      mb_ls <= ((mb_p + 1) % HT_B) == 0;
      mb_fs <= (mb_p + 1) == TOT_B;
      mb_fr <= mb_fr + (((mb_p + 1) == TOT_B) ? 1 : 0);
      mb_gt <= ((mb_p + 1) == TOT_B) && (((mb_fr + 1) % 3) == 0);
      mc_p  <= (mc_p + 1) % TOT_C;
      mc_ls <= ((mc_p + 1) % HT_C) == 0;
      mc_fs <= (mc_p + 1) == TOT_C;
      mc_fr <= mc_fr + (((mc_p + 1) == TOT_C) ? 1 : 0);
      mc_gt <= ((mc_p + 1) == TOT_C) && (((mc_fr + 1) % 60) == 0);
    end else begin
      ma_ls <= 1'b0; ma_fs <= 1'b0; ma_gt <= 1'b0;
      mb_ls <= 1'b0; mb_fs <= 1'b0; mb_gt <= 1'b0;
      mc_ls <= 1'b0; mc_fs <= 1'b0; mc_gt <= 1'b0;
    end
  end

  task automatic cmp(input string nm,
                     input int h, input int v, input int hs, input int vs, input int bl,
                     input int ls, input int fs, input int fc, input int gt,
                     input int mp, input int mfr, input int mls, input int mfs, input int mgt,
                     input int ht, input int ha, input int hfp, input int hsw,
                     input int va, input int vfp, input int vsw);
    int eh;
    int ev;
    eh = mp % ht;
    ev = mp / ht;
    chk({nm, " hcount"}, h, eh);
    chk({nm, " vcount"}, v, ev);
    chk({nm, " blank"}, bl, ((eh >= ha) || (ev >= va)) ? 1 : 0);
    chk({nm, " hsync"}, hs, ((eh >= ha + hfp) && (eh < ha + hfp + hsw)) ? 0 : 1);
    chk({nm, " vsync"}, vs, ((ev >= va + vfp) && (ev < va + vfp + vsw)) ? 0 : 1);
    chk({nm, " line_start"}, ls, mls);
    chk({nm, " frame_start"}, fs, mfs);
    chk({nm, " frame_count"}, fc, mfr % 256);
    chk({nm, " game_tick"}, gt, mgt);
  endtask

  logic tally_en = 1'b0;
  int b_fs_n = 0, b_first_tick = 0, b_ticks = 0, b_run = 0, b_run_max = 0;
  int c_prev_h = 0, c_prev_v = 0, c_seen = 0, c_vs_low = 0;

  // Single compare process: per-cycle model checks plus boundary tallies.
  always @(negedge clk) begin
    cmp("A", int'(a_h), int'(a_v), int'(a_hs), int'(a_vs), int'(a_bl), int'(a_ls), int'(a_fs),
        int'(a_fc), int'(a_gt), ma_p, ma_fr, int'(ma_ls), int'(ma_fs), int'(ma_gt),
        HT_A, 1024, 24, 136, 768, 3, 6);
    cmp("B", int'(b_h), int'(b_v), int'(b_hs), int'(b_vs), int'(b_bl), int'(b_ls), int'(b_fs),
        int'(b_fc), int'(b_gt), mb_p, mb_fr, int'(mb_ls), int'(mb_fs), int'(mb_gt),
        HT_B, 4, 1, 1, 2, 1, 1);
    cmp("C", int'(c_h), int'(c_v), int'(c_hs), int'(c_vs), int'(c_bl), int'(c_ls), int'(c_fs),
        int'(c_fc), int'(c_gt), mc_p, mc_fr, int'(mc_ls), int'(mc_fs), int'(mc_gt),
        HT_C, 1024, 24, 136, 4, 3, 6);
    if (tally_en) begin
      if (b_fs) begin
        b_fs_n++;
        if (b_fs_n == 256) chk("B frame_count wrap at 256", int'(b_fc), 0);
        if (b_gt && b_first_tick == 0) b_first_tick = b_fs_n;
      end
      if (b_gt) b_ticks++;
      b_run = b_fs ? b_run + 1 : 0;
      if (b_run > b_run_max) b_run_max = b_run;
      if (c_fs && c_seen == 0) begin
        c_seen = 1;
        chk("C prev hcount before wrap", c_prev_h, 1343);
        chk("C prev vcount before wrap", c_prev_v, 14);
        chk("C wrap hcount", int'(c_h), 0);
        chk("C wrap vcount", int'(c_v), 0);
        chk("C wrap line_start", int'(c_ls), 1);
        chk("C wrap frame_count", int'(c_fc), 1);
      end
      if (!c_vs && c_fc == 8'd0) c_vs_low++;
    end
    c_prev_h = int'(c_h);
    c_prev_v = int'(c_v);
  end

  int found;
  int hs_low;
  int first_blank;
  int ls_n;

  initial begin
    rst_n = 1'b1;
    pen   = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset hcount", int'(a_h), 0);
    chk("reset vcount", int'(a_v), 0);
    chk("reset hsync", int'(a_hs), 1);
    chk("reset vsync", int'(a_vs), 1);
    chk("reset blank", int'(a_bl), 0);
    chk("reset frame_count", int'(a_fc), 0);

    @(posedge clk); #2;
    rst_n = 1'b1;
    pen   = 1'b1;
    repeat (500) @(posedge clk);
    #1 chk("A hcount after 500", int'(a_h), 500);
    #1 rst_n = 1'b0;
    #1;
    chk("async reset hcount", int'(a_h), 0);
    chk("async reset vcount", int'(a_v), 0);
    chk("async reset hsync", int'(a_hs), 1);
    chk("async reset blank", int'(a_bl), 0);
    chk("async reset frame_count B", int'(b_fc), 0);

    @(posedge clk); #2;
    rst_n    = 1'b1;
    tally_en = 1'b1;
    @(posedge clk); #1;
    chk("first edge hcount", int'(a_h), 1);
    chk("first edge frame_start", int'(a_fs), 0);
    chk("first edge line_start", int'(a_ls), 0);
    #1;
    for (int i = 0; i < 120; i++) begin
      pen = (i % 2 == 0);
      @(posedge clk); #2;
    end
    pen = 1'b1;

    found = 0;
    for (int i = 0; i < 3000 && found == 0; i++) begin
      @(negedge clk);
      if (a_ls) found = 1;
    end
    chk("A line_start seen", found, 1);
    hs_low = 0;
    first_blank = -1;
    ls_n = 0;
    for (int i = 0; i < 1344; i++) begin
      if (i > 0) @(negedge clk);
      if (!a_hs) hs_low++;
      if (a_bl && first_blank < 0) first_blank = int'(a_h);
      if (a_ls) ls_n++;
    end
    chk("A hsync low cycles per line", hs_low, 136);
    chk("A blank first hcount", first_blank, 1024);
    chk("A line_start per line", ls_n, 1);

    @(posedge clk); #2;
    found = 0;
    for (int i = 0; i < 30000 && found == 0; i++) begin
      if (mc_p == TOT_C - 3) found = 1;
      else begin
        @(posedge clk); #2;
      end
    end
    chk("C reached pre-wrap", found, 1);
    for (int i = 0; i < 8; i++) begin
      pen = (i % 2 == 1);
      @(posedge clk); #2;
    end
    pen = 1'b1;
    repeat (50) @(posedge clk);
    @(negedge clk);

    chk("C frame wrap seen", c_seen, 1);
    chk("C vsync low cycles", c_vs_low, 6 * 1344);
    chk("B enough frames", (b_fs_n >= 256) ? 1 : 0, 1);
    chk("B first tick frame", b_first_tick, 3);
    chk("B tick count", b_ticks, b_fs_n / 3);
    chk("B frame_start max run", b_run_max, 1);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
